// File: rtl/ddr4_train_sched.sv
// Round-robin scheduler that time-shares one training datapath across RANKS ranks.
// Optional build macro DDR4_SCHED_DRIFT_PRIO_EN: drift-requested ranks are served ahead of init/periodic ones.
module ddr4_train_sched #(
    parameter int RANKS            = 4,
    parameter int RETRAIN_INTERVAL = 65536,
    parameter int QUIESCE_TIMEOUT  = 256,
    parameter int WATCHDOG_CYCLES  = 4096,
    parameter int FAIL_LIMIT       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     init_req,
    input  logic [RANKS-1:0]         drift_req,
    output logic                     quiesce_req,
    input  logic                     quiesce_ack,
    output logic                     train_start,
    output logic [$clog2(RANKS)-1:0] train_sel,
    input  logic                     train_done,
    input  logic                     train_failed,
    output logic [RANKS-1:0]         rank_trained,
    output logic [RANKS-1:0]         rank_dead,
    output logic                     busy,
    output logic                     init_complete,
    output logic                     watchdog_err,
    output logic [7:0]               quiesce_err_cnt
);

    localparam int SEL_W = $clog2(RANKS);
    localparam int FCW   = $clog2(FAIL_LIMIT + 1);

    typedef enum logic [2:0] {IDLE, QUIESCE, START, RUN, RELEASE} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d, rr_q, rr_d, pick;
    logic [31:0]      cnt_q, cnt_d, timer_q, timer_d;
    logic [RANKS-1:0] trained_q, trained_d, dead_q, dead_d;
    logic [FCW-1:0]   fail_cnt_q [RANKS];
    logic [FCW-1:0]   fail_cnt_d [RANKS];
    logic             wd_err_q, wd_err_d;
    logic [7:0]       qerr_q, qerr_d;
    logic             init_done_q, init_done_d;
    logic             init_seen_q, init_seen_d;
    logic             init_pend_q, init_pend_d;
    logic             init_apply;
    logic [RANKS-1:0] pend_all, set_drift, set_other, clr, sel_oh;

    // First set bit of vec at or after ptr, wrapping around.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [RANKS-1:0] vec,
                                                 input logic [SEL_W-1:0] ptr);
        logic [2*RANKS-1:0] dbl;
        logic [RANKS-1:0]   rot;
        int                 off;
        int                 sum;
        dbl = {vec, vec} >> ptr;
        rot = dbl[RANKS-1:0];
        off = 0;
        for (int k = RANKS - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        sum = int'(ptr) + off;
        if (sum >= RANKS) sum = sum - RANKS;
        return SEL_W'(sum);
    endfunction

`ifdef DDR4_SCHED_DRIFT_PRIO_EN
    logic [RANKS-1:0] pend_drift_q, pend_drift_d, pend_main_q, pend_main_d;
    assign pend_all = pend_drift_q | pend_main_q;
    assign pick     = (|pend_drift_q) ? rr_pick(pend_drift_q, rr_q) : rr_pick(pend_main_q, rr_q);
`else
    logic [RANKS-1:0] pend_q, pend_d;
    assign pend_all = pend_q;
    assign pick     = rr_pick(pend_q, rr_q);
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        trained_d   = trained_q;
        dead_d      = dead_q;
        fail_cnt_d  = fail_cnt_q;
        wd_err_d    = wd_err_q;
        qerr_d      = qerr_q;
        init_done_d = init_done_q;
        init_seen_d = init_seen_q;
        clr         = '0;
        set_other   = '0;
        set_drift   = drift_req & ~dead_q;
        sel_oh      = RANKS'(1) << sel_q;
        // An init arriving mid-run is parked until the controller is released.
        init_apply  = (init_req || init_pend_q) && (state_q == IDLE || state_q == RELEASE);
        init_pend_d = (init_req || init_pend_q) && !init_apply;

        if (enable && init_done_q && state_q == IDLE) begin
            if (timer_q == 32'(RETRAIN_INTERVAL - 1)) begin
                timer_d   = '0;
                set_other = trained_q & ~dead_q;
            end else begin
                timer_d = timer_q + 32'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (init_seen_q && pend_all == '0 && &(trained_q | dead_q)) init_done_d = 1'b1;
                if (enable && pend_all != '0) begin
                    sel_d   = pick;
                    cnt_d   = '0;
                    state_d = QUIESCE;
                end
            end
            QUIESCE: begin
                if (quiesce_ack) begin
                    state_d = START;
                end else if (cnt_q == 32'(QUIESCE_TIMEOUT - 1)) begin
                    if (qerr_q != 8'hFF) qerr_d = qerr_q + 8'd1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (train_failed || train_done || cnt_q == 32'(WATCHDOG_CYCLES - 1)) begin
                    state_d = RELEASE;
                    if (!train_failed && !train_done) wd_err_d = 1'b1;
                    // A pending init supersedes this run's outcome.
                    if (!init_pend_q && !init_req) begin
                        for (int i = 0; i < RANKS; i++) begin
                            if (sel_oh[i]) begin
                                if (train_done && !train_failed) begin
                                    trained_d[i]  = 1'b1;
                                    fail_cnt_d[i] = '0;
                                    clr[i]        = 1'b1;
                                end else if (fail_cnt_q[i] == FCW'(FAIL_LIMIT - 1)) begin
                                    dead_d[i]     = 1'b1;
                                    trained_d[i]  = 1'b0;
                                    fail_cnt_d[i] = FCW'(FAIL_LIMIT);
                                    clr[i]        = 1'b1;
                                end else begin
                                    fail_cnt_d[i] = fail_cnt_q[i] + FCW'(1);
                                end
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RELEASE: begin
                rr_d = (sel_q == SEL_W'(RANKS - 1)) ? '0 : sel_q + SEL_W'(1);
                if (!quiesce_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (init_apply) begin
            trained_d   = '0;
            dead_d      = '0;
            init_done_d = 1'b0;
            init_seen_d = 1'b1;
            set_other   = '1;
            for (int i = 0; i < RANKS; i++) fail_cnt_d[i] = '0;
        end

        // Sets are OR-ed after the clear so a same-cycle request keeps the rank pending.
`ifdef DDR4_SCHED_DRIFT_PRIO_EN
        pend_drift_d = (pend_drift_q & ~clr) | set_drift;
        pend_main_d  = (pend_main_q & ~clr) | set_other;
`else
        pend_d = (pend_q & ~clr) | set_drift | set_other;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            trained_q   <= '0;
            dead_q      <= '0;
            fail_cnt_q  <= '{default: '0};
            wd_err_q    <= 1'b0;
            qerr_q      <= '0;
            init_done_q <= 1'b0;
            init_seen_q <= 1'b0;
            init_pend_q <= 1'b0;
`ifdef DDR4_SCHED_DRIFT_PRIO_EN
            pend_drift_q <= '0;
            pend_main_q  <= '0;
`else
            pend_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            trained_q   <= trained_d;
            dead_q      <= dead_d;
            fail_cnt_q  <= fail_cnt_d;
            wd_err_q    <= wd_err_d;
            qerr_q      <= qerr_d;
            init_done_q <= init_done_d;
            init_seen_q <= init_seen_d;
            init_pend_q <= init_pend_d;
`ifdef DDR4_SCHED_DRIFT_PRIO_EN
            pend_drift_q <= pend_drift_d;
            pend_main_q  <= pend_main_d;
`else
            pend_q       <= pend_d;
`endif
        end
    end

    assign quiesce_req     = (state_q == QUIESCE) || (state_q == START) || (state_q == RUN);
    assign train_start     = (state_q == START);
    assign train_sel       = sel_q;
    assign rank_trained    = trained_q;
    assign rank_dead       = dead_q;
    assign busy            = (state_q != IDLE);
    assign init_complete   = init_done_q;
    assign watchdog_err    = wd_err_q;
    assign quiesce_err_cnt = qerr_q;

endmodule
